// File: rtl/bitstream_loader.sv
// Byte-stream to serial programming-chain loader with CRC-8 readback of the old chain contents.
// Each chain bit takes two system clocks (LO presents the bit, HI raises prog_clk).
module bitstream_loader #(
  parameter int CHAIN_LEN = 256,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       prog_clk,
  output logic       prog_en,
  output logic       prog_in,
  input  logic       prog_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] rb_crc
);

  localparam int              NBYTES   = (CHAIN_LEN + 7) / 8;
  localparam logic [CNT_W-1:0] NBYTES_C = CNT_W'(NBYTES);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(CHAIN_LEN - 1);

  // IDLE: wait for start | WAIT: need a byte | LO: present bit | HI: chain edge | FINISH: done pulse
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LO, S_HI, S_FINISH} state_t;

  state_t           state_q, state_d;
  logic [7:0]       sr_q, sr_d;
  logic [3:0]       sr_cnt_q, sr_cnt_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CNT_W-1:0] bits_q, bits_d;
  logic [CNT_W-1:0] bytes_q, bytes_d;
  logic [7:0]       crc_q, crc_d;
  logic             handshake;

  assign busy      = (state_q == S_WAIT) || (state_q == S_LO) || (state_q == S_HI);
  assign s_ready   = busy && !hold_full_q && (bytes_q < NBYTES_C);
  assign handshake = s_valid && s_ready;
  assign rb_crc    = crc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sr_q        <= 8'h00;
      sr_cnt_q    <= 4'd0;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      bits_q      <= '0;
      bytes_q     <= '0;
      crc_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      sr_cnt_q    <= sr_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bits_q      <= bits_d;
      bytes_q     <= bytes_d;
      crc_q       <= crc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    sr_cnt_d    = sr_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bits_d      = bits_q;
    bytes_d     = bytes_q;
    crc_d       = crc_q;
    prog_clk    = 1'b0;
    prog_en     = 1'b0;
    prog_in     = 1'b0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          bits_d      = '0;
          bytes_d     = '0;
          crc_d       = 8'h00;
          sr_cnt_d    = 4'd0;
          hold_full_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        prog_en = 1'b1;
        if (sr_cnt_q == 4'd0 && hold_full_q) begin
          sr_d        = hold_q;
          sr_cnt_d    = 4'd8;
          hold_full_d = 1'b0;
          state_d     = S_LO;
        end
      end
      S_LO: begin
        prog_en = 1'b1;
        prog_in = sr_q[0];
        crc_d   = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ prog_out) ? 8'h07 : 8'h00);
        state_d = S_LO == S_LO ? S_HI : S_HI;
      end
      S_HI: begin
        prog_en  = 1'b1;
        prog_clk = 1'b1;
        prog_in  = sr_q[0];
        sr_d     = {1'b0, sr_q[7:1]};
        sr_cnt_d = sr_cnt_q - 4'd1;
        bits_d   = bits_q + CNT_W'(1);
        if (bits_q == LAST_C) begin
          state_d = S_FINISH;
        end else if (sr_cnt_q > 4'd1) begin
          state_d = S_LO;
        end else if (hold_full_q) begin
          // back-to-back reload keeps prog_clk running without a WAIT gap
          sr_d        = hold_q;
          sr_cnt_d    = 4'd8;
          hold_full_d = 1'b0;
          state_d     = S_LO;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (handshake) begin
      hold_d      = s_data;
      hold_full_d = 1'b1;
      bytes_d     = bytes_q + CNT_W'(1);
    end
  end

endmodule
